fifo_stream_reader: RTL and testbench

- Drains the read side of the team's async FIFO in the read-clock domain and presents the words as a valid/ready stream.
- Hides the FIFO's fixed read latency with prefetch and a small output buffer.
- Sustains one word per cycle under continuous ready, and holds data stable under backpressure.
- Keeps a delivered-word counter for debug and throughput checks.

---
 rtl/fifo_stream_reader.sv | 104 ++++++++++
 tb/tb_fifo_stream_reader.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/fifo_stream_reader.sv
// fifo_stream_reader
//   Drains the read side of the async FIFO in the rdclk domain. It presents the
//   words as a valid/ready stream. The FIFO's fixed read latency is hidden by
//   prefetching into a small circular buffer. That buffer is sized so that
//   continuous m_ready sustains one word per cycle.
//
// Ports
//   rdclk        read-side clock
//   reset        synchronous, active-high
//   fifo_empty   FIFO empty flag (rdclk domain)
//   fifo_rd      FIFO pop strobe
//   fifo_dataout FIFO read data, valid RDLAT cycles after fifo_rd
//   m_valid      output word valid
//   m_ready      downstream accept
//   m_data       output word
//   words_out    delivered-word counter, wraps modulo 2^COUNTW
module fifo_stream_reader #(
  parameter int WIDTH  = 8,
  parameter int RDLAT  = 1,
  parameter int COUNTW = 16
) (
  input  logic              rdclk,
  input  logic              reset,
  input  logic              fifo_empty,
  output logic              fifo_rd,
  input  logic [WIDTH-1:0]  fifo_dataout,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [WIDTH-1:0]  m_data,
  output logic [COUNTW-1:0] words_out
);

  // Two slots beyond the latency: one word being presented and one word of
  // slack. This lets the prefetcher keep issuing every cycle in steady state.
  localparam int DEPTH = RDLAT + 2;
  localparam int PW    = $clog2(DEPTH);
  localparam int CW    = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] buf_q [DEPTH];
  logic [PW-1:0]    wptr, rptr;
  logic [CW-1:0]    count;
  // vld_pipe[k] set: an issued read whose data lands k cycles later.
  // vld_pipe[1] marks the data on fifo_dataout this cycle.
  logic [RDLAT:1]   vld_pipe;
  logic [CW-1:0]    inflight;
  logic             cap, xfer;

  // DEPTH is not a power of two in general, so wrap explicitly.
  function automatic logic [PW-1:0] inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  always_comb begin
    inflight = '0;
    for (int k = 1; k <= RDLAT; k++) inflight = inflight + CW'(vld_pipe[k]);
  end

  // Reserve a buffer slot for every outstanding read. m_ready is deliberately
  // not consulted, so no combinational path exists from m_ready to fifo_rd.
  assign fifo_rd = !reset && !fifo_empty &&
                   (({1'b0, count} + {1'b0, inflight}) < (CW+1)'(DEPTH));

  assign cap     = vld_pipe[1];
  assign m_valid = (count != '0);
  assign m_data  = buf_q[rptr];
  assign xfer    = m_valid && m_ready;

  always_ff @(posedge rdclk) begin
    if (reset) begin
      wptr      <= '0;
      rptr      <= '0;
      count     <= '0;
      vld_pipe  <= '0;
      words_out <= '0;
      for (int i = 0; i < DEPTH; i++) buf_q[i] <= '0;
    end else begin
      vld_pipe[RDLAT] <= fifo_rd;
      for (int k = 1; k < RDLAT; k++) vld_pipe[k] <= vld_pipe[k+1];

      if (cap) begin
        buf_q[wptr] <= fifo_dataout;
        wptr        <= inc(wptr);
      end

      if (xfer) begin
        rptr      <= inc(rptr);
        words_out <= words_out + COUNTW'(1);
      end

      // Simultaneous capture and transfer leaves the count unchanged.
      case ({cap, xfer})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: ;
      endcase
    end
  end

  // The issue rule reserves space, so a capture into a full buffer is only
  // possible if that reservation logic is broken.
  a_no_overflow: assert property (@(posedge rdclk) disable iff (reset)
    !(cap && (count == CW'(DEPTH)) && !xfer));

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Scoreboard bench for fifo_stream_reader. It contains a queue-based model of
// the async FIFO read side, and the FIFO model drives the DUT inputs. Every pop
// that the model sees pushes the popped word into an expected queue. A monitor
// compares each accepted output word against that queue. It also tracks the
// expected words_out value and checks that stalled words stay stable.
module tb_fifo_stream_reader;
  localparam int WIDTH  = 8;
  localparam int RDLAT  = 2;
  localparam int COUNTW = 4;
  localparam int DEPTH  = RDLAT + 2;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              fifo_empty = 1'b1;
  logic              fifo_rd;
  logic [WIDTH-1:0]  fifo_dataout = '0;
  logic              m_valid;
  logic              m_ready = 1'b0;
  logic [WIDTH-1:0]  m_data;
  logic [COUNTW-1:0] words_out;

  int checks = 0, errors = 0;
  logic [WIDTH-1:0] fq[$];
  logic [WIDTH-1:0] exp_q[$];
  logic [WIDTH-1:0] pend [RDLAT];
  logic [WIDTH-1:0] last_pop = '0;
  int pops = 0, delivered = 0, wo_model = 0;
  bit rst_prev = 1'b1, prev_stall = 1'b0;
  logic [WIDTH-1:0] prev_data = '0;

  always #5 clk = ~clk;

  fifo_stream_reader #(.WIDTH(WIDTH), .RDLAT(RDLAT), .COUNTW(COUNTW)) dut (
    .rdclk(clk), .reset(reset), .fifo_empty(fifo_empty), .fifo_rd(fifo_rd),
    .fifo_dataout(fifo_dataout), .m_valid(m_valid), .m_ready(m_ready),
    .m_data(m_data), .words_out(words_out)
  );

  task automatic chk(input bit ok, input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  // This block runs mid-cycle: the FIFO model first, then the scoreboard monitor.
  always @(negedge clk) begin
    logic [WIDTH-1:0] w;
    for (int i = RDLAT-1; i > 0; i--) pend[i] = pend[i-1];
    pend[0]      = last_pop;
    fifo_dataout = pend[RDLAT-1];   // word popped RDLAT cycles ago (or junk)
    fifo_empty   = (fq.size() == 0);
    #1;
    last_pop = WIDTH'($urandom);
    if (fifo_rd) begin
      if (fq.size() == 0) chk(1'b0, "rd_when_empty", 1, 0);
      else begin
        w = fq.pop_front();
        last_pop = w;
        exp_q.push_back(w);
        pops++;
      end
    end
    if (reset) begin
      chk(fifo_rd == 1'b0, "rd_in_reset", fifo_rd, 0);
      if (rst_prev) begin
        chk(m_valid == 1'b0, "rst_valid", m_valid, 0);
        chk(m_data == '0, "rst_data", m_data, 0);
        chk(words_out == '0, "rst_words", words_out, 0);
      end
      exp_q.delete();
      wo_model   = 0;
      prev_stall = 1'b0;
    end else begin
      chk(words_out == COUNTW'(wo_model), "words_out", words_out, COUNTW'(wo_model));
      if (prev_stall) begin
        chk(m_valid == 1'b1, "stall_valid", m_valid, 1);
        chk(m_data == prev_data, "stall_data", m_data, prev_data);
      end
      if (m_valid && m_ready) begin
        if (exp_q.size() == 0) chk(1'b0, "unexpected_word", m_data, 0);
        else begin
          w = exp_q.pop_front();
          chk(m_data == w, "data_order", m_data, w);
        end
        wo_model++;
        delivered++;
      end
      prev_stall = m_valid && !m_ready;
      prev_data  = m_data;
    end
    rst_prev = reset;
  end

  // Inputs change 1 time unit after the active edge.
  task automatic cyc(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  // Call this in cycle 0, right after the stimulus has been applied. The read
  // should issue in cycle 0, and m_valid should first rise in cycle RDLAT+1.
  task automatic check_latency(input string nm);
    bit seen = 1'b0;
    for (int c = 0; c < 20 && !seen; c++) begin
      @(negedge clk); #2;
      if (c == 0) chk(fifo_rd == 1'b1, "first_rd", fifo_rd, 1);
      if (m_valid) begin
        seen = 1'b1;
        chk(c == RDLAT + 1, nm, c, RDLAT + 1);
      end
    end
    if (!seen) chk(1'b0, {nm, "_timeout"}, 0, 1);
  endtask

  initial begin
    int p0, gaps, rd_hits, vld_hits, d0, n;
    for (int i = 0; i < RDLAT; i++) pend[i] = '0;

    // Reset held with a non-empty FIFO, then stream 4 words.
    for (int i = 1; i <= 4; i++) fq.push_back(WIDTH'(i));
    cyc(4);
    reset = 1'b0; m_ready = 1'b1;
    check_latency("stream_latency");
    cyc(10);
    chk(words_out == 4'd4, "stream_words", words_out, 4);
    chk(fq.size() == 0, "stream_drained", fq.size(), 0);
    chk(fifo_rd == 1'b0, "stream_rd_idle", fifo_rd, 0);

    // Backpressure: prefetch stops at DEPTH, head word holds, then resume.
    m_ready = 1'b0;
    p0 = pops;
    for (int i = 0; i < 8; i++) fq.push_back(WIDTH'(8'h10 + i));
    cyc(10);
    chk(pops - p0 == DEPTH, "bp_pops", pops - p0, DEPTH);
    chk(m_valid == 1'b1, "bp_valid", m_valid, 1);
    chk(m_data == 8'h10, "bp_head", m_data, 8'h10);
    m_ready = 1'b1;
    gaps = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk); #2;
      if (!m_valid) gaps++;
    end
    chk(gaps == 0, "bp_gaps", gaps, 0);
    cyc(5);
    chk(words_out == 4'd12, "bp_words", words_out, 12);

    // Empty FIFO with toggling ready.
    rd_hits = 0; vld_hits = 0;
    for (int i = 0; i < 20; i++) begin
      m_ready = ~m_ready;
      @(negedge clk); #2;
      if (fifo_rd) rd_hits++;
      if (m_valid) vld_hits++;
      cyc(1);
    end
    chk(rd_hits == 0, "empty_rd", rd_hits, 0);
    chk(vld_hits == 0, "empty_valid", vld_hits, 0);

    // Reset while two words are buffered and two are in flight.
    m_ready = 1'b0;
    for (int i = 0; i < 8; i++) fq.push_back(WIDTH'(8'h30 + i));
    cyc(4);
    reset = 1'b1;
    fq.delete();
    cyc(1);
    reset = 1'b0;
    fq.push_back(8'hA0);
    m_ready = 1'b1;
    check_latency("post_reset_latency");
    cyc(4);
    chk(words_out == 4'd1, "post_reset_words", words_out, 1);

    // Counter wrap with random ready: 17 words into a 4-bit counter.
    reset = 1'b1;
    cyc(2);
    reset = 1'b0;
    d0 = delivered;
    for (int i = 0; i < 17; i++) fq.push_back(WIDTH'($urandom));
    n = 0;
    while (delivered - d0 < 17 && n < 400) begin
      m_ready = 1'($urandom_range(0, 1));
      cyc(1);
      n++;
    end
    m_ready = 1'b0;
    cyc(2);
    chk(delivered - d0 == 17, "wrap_delivered", delivered - d0, 17);
    chk(words_out == 4'd1, "wrap_words", words_out, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
